// File: rtl/dct_stage2_row_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dct_stage2_row_reader
//  Brief    : Single-buffer 8x8 transpose between the row-DCT and column-DCT
//             stages: fills one column per handshake, drains one row per
//             handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module dct_stage2_row_reader #(
    parameter int SIZE = 2
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active-low
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0][SIZE-1:0]  col_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0][SIZE-1:0]  row_out,
    output logic [2:0]            row_idx,
    output logic                  out_last
);

    localparam logic [0:0] c_ST_FILL  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [2:0]      r_wr_col;
    logic [2:0]      r_rd_row;
    logic [SIZE-1:0] r_mem [8][8];
    logic            w_accept;
    logic            w_take;

    // Handshakes qualify only on the registered state, so the ready/valid
    // outputs never depend combinationally on in_valid or out_ready.
    assign w_accept = in_valid  && (r_state == c_ST_FILL);
    assign w_take   = out_ready && (r_state == c_ST_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_FILL: begin
                if (w_accept && (r_wr_col == 3'd7)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_take && (r_rd_row == 3'd7)) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            default: w_state_nxt = c_ST_FILL;
        endcase
    end

    // Both counters wrap 7 -> 0 naturally on the block boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_col <= 3'd0;
            r_rd_row <= 3'd0;
        end else begin
            if (w_accept) begin
                r_wr_col <= r_wr_col + 3'd1;
            end
            if (w_take) begin
                r_rd_row <= r_rd_row + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < 8; r++) begin
                r_mem[r][r_wr_col] <= col_in[r];
            end
        end
    end

    always_comb begin
        in_ready  = (r_state == c_ST_FILL);
        out_valid = (r_state == c_ST_DRAIN);
        row_idx   = r_rd_row;
        out_last  = (r_state == c_ST_DRAIN) && (r_rd_row == 3'd7);
        for (int c = 0; c < 8; c++) begin
            row_out[c] = r_mem[r_rd_row][c];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_stage2_row_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dct_stage2_row_reader
//  Brief    : Directed self-checking bench; an 8-bit and a 2-bit instance run
//             in lockstep on the same handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dct_stage2_row_reader;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [7:0][7:0]  col_in;
    logic [7:0][1:0]  col_in2;

    logic             in_ready,  in_ready2;
    logic             out_valid, out_valid2;
    logic [7:0][7:0]  row_out;
    logic [7:0][1:0]  row_out2;
    logic [2:0]       row_idx,   row_idx2;
    logic             out_last,  out_last2;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] blk [8][8];   // blk[row][col] of the block currently in flight

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            col_in2[r] = col_in[r][1:0];
        end
    end

    dct_stage2_row_reader #(.SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .col_in(col_in),
        .out_valid(out_valid), .out_ready(out_ready), .row_out(row_out),
        .row_idx(row_idx), .out_last(out_last)
    );

    dct_stage2_row_reader #(.SIZE(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .col_in(col_in2),
        .out_valid(out_valid2), .out_ready(out_ready), .row_out(row_out2),
        .row_idx(row_idx2), .out_last(out_last2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[c*8 +: 8] = blk[r][c];
        return v;
    endfunction

    function automatic logic [15:0] exp_row2(input int r);
        logic [15:0] v;
        for (int c = 0; c < 8; c++) v[c*2 +: 2] = blk[r][c][1:0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present column k of blk and hold it until accepted; optional idle gap after.
    task automatic push(input int k, input bit gap);
        int n = 0;
        for (int r = 0; r < 8; r++) col_in[r] = blk[r][k];
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("push_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        if (gap) begin
            col_in = {$urandom, $urandom};
            tick();
        end
    endtask

    // Drain eight rows, optionally stalling at one row and pushing junk columns.
    task automatic drain(input int stall_row, input int stall_cyc, input bit junk);
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("drain_valid", 64'(out_valid), 64'd1);
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int i = 0; i < stall_cyc; i++) begin
                    if (junk) begin
                        in_valid = 1'b1;
                        col_in   = {$urandom, $urandom};
                    end
                    chk("stall_idx",   64'(row_idx), 64'(r));
                    chk("stall_row",   row_out, exp_row(r));
                    chk("stall_ready", 64'(in_ready), 64'd0);
                    tick();
                end
                out_ready = 1'b1;
            end
            if (junk) begin
                in_valid = 1'b1;
                col_in   = {$urandom, $urandom};
            end
            chk("row_idx",   64'(row_idx), 64'(r));
            chk("out_last",  64'(out_last), 64'(r == 7));
            chk("row_out",   row_out, exp_row(r));
            chk("row_out2",  64'(row_out2), 64'(exp_row2(r)));
            chk("row_idx2",  64'(row_idx2), 64'(r));
            chk("out_last2", 64'(out_last2), 64'(r == 7));
            chk("drain_rdy", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("refill_ready",  64'(in_ready), 64'd1);
        chk("refill_ready2", 64'(in_ready2), 64'd1);
        chk("refill_valid",  64'(out_valid), 64'd0);
        chk("refill_valid2", 64'(out_valid2), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_row_out"},   row_out, 64'd0);
        chk({tag, "_row_idx"},   64'(row_idx), 64'd0);
        chk({tag, "_out_last"},  64'(out_last), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        col_in    = '0;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Transpose of a parity pattern, back-to-back columns.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 8'((r + c) % 2);
        for (int k = 0; k < 7; k++) push(k, 1'b0);
        chk("pre_last_valid", 64'(out_valid), 64'd0);
        push(7, 1'b0);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_ready", 64'(in_ready), 64'd0);
        drain(-1, 0, 1'b0);

        // Sign/width extremes in column 3, backpressure at row 2, junk during drain.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 8'(c * 16 + r);
        blk[0][3] = 8'h80; blk[1][3] = 8'h7F; blk[2][3] = 8'hFF; blk[3][3] = 8'h00;
        blk[4][3] = 8'h01; blk[5][3] = 8'hFE; blk[6][3] = 8'h40; blk[7][3] = 8'hC0;
        for (int k = 0; k < 8; k++) push(k, 1'b0);
        drain(2, 5, 1'b1);

        // Gapped input: only handshaked columns land, in order.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 8'(8'hA0 + r * 8 + c);
        for (int k = 0; k < 7; k++) push(k, 1'b1);
        chk("gap_ready", 64'(in_ready), 64'd1);
        chk("gap_valid", 64'(out_valid), 64'd0);
        push(7, 1'b0);
        drain(-1, 0, 1'b0);

        // Reset after five columns; stale column held on the bus during reset.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 8'h5A ^ 8'(r * 8 + c);
        for (int k = 0; k < 5; k++) push(k, 1'b0);
        in_valid = 1'b1;
        col_in   = {8{8'h3C}};
        #2 rst = 1'b0;
        #1 check_reset_outputs("midfill");
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 8'(8'h10 + r * 8 + c);
        for (int k = 0; k < 8; k++) push(k, 1'b0);
        drain(-1, 0, 1'b0);

        // Async reset in the middle of a drain.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 8'(8'hE1 - r * 8 - c);
        for (int k = 0; k < 8; k++) push(k, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("middrain_idx", 64'(row_idx), 64'd2);
        chk("middrain_row", row_out, exp_row(2));
        #2 rst = 1'b0;
        #1 check_reset_outputs("middrain");
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
